// File: rtl/pci_target_mem.sv
// pci_target_mem: PCI-style target storage behind the slave bus interface.
// A DEPTH-word register file with per-byte write enables, wrapping bursts,
// a registered TRDY/DEVSEL handshake with programmable wait states, and a
// ring of snapshot buffers that captures the whole store after every write
// transaction.
//
// Handshake: a data transfer happens on every rising edge where the target
// is in its data state (TRDY low) and the initiator holds IRDY low. FRAME
// high on a transfer edge marks that beat as the last one. The target never
// transfers while IRDY is high, and it drives Data only while a read is in
// its wait or data period.
module pci_target_mem #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 4,
  parameter int ADDR_W      = $clog2(DEPTH),
  parameter int WAIT_STATES = 0,
  parameter int SNAP_SLOTS  = 2,
  localparam int SEL_W      = (SNAP_SLOTS > 1) ? $clog2(SNAP_SLOTS) : 1,
  localparam int BYTES      = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  inout  wire  [DATA_W-1:0] Data,
  input  logic              F,
  input  logic              I,
  input  logic [ADDR_W-1:0] Address,
  input  logic              RE,
  input  logic              WE,
  input  logic [BYTES-1:0]  BE,
  output logic              T,
  output logic              D,
  output logic [ADDR_W-1:0] Ptr,
  input  logic [SEL_W-1:0]  SnapSel,
  input  logic [ADDR_W-1:0] SnapIdx,
  output logic [DATA_W-1:0] SnapData,
  output logic [3:0]        SnapCount
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_DATA   = 3'd2,
    S_IGNORE = 3'd3,
    S_TURN   = 3'd4
  } state_t;

  // state is kept as a named signal so checkers can bind to it directly
  state_t state;
  state_t next_state;

  logic              is_write;
  logic [3:0]        wait_cnt;
  logic [DATA_W-1:0] mem  [DEPTH];
  logic [DATA_W-1:0] snap [SNAP_SLOTS][DEPTH];
  logic [SEL_W-1:0]  wr_slot;
  logic [3:0]        snap_count;

  logic              xfer;
  logic              ptr_ok;
  logic [ADDR_W-1:0] ptr_inc;
  logic [DATA_W-1:0] rd_word;
  logic              rd_drive;
  logic              snap_ok;

  // Transfer qualification, pointer wrap and read-word selection
  always_comb begin
    xfer    = (state == S_DATA) && !I;
    // Address may exceed DEPTH-1 when DEPTH is not a power of two
    ptr_ok  = (32'(Ptr) < 32'(DEPTH));
    ptr_inc = (32'(Ptr) >= 32'(DEPTH - 1)) ? '0 : Ptr + ADDR_W'(1);
    rd_word = ptr_ok ? mem[Ptr] : '0;
    rd_drive = !is_write && ((state == S_WAIT) || (state == S_DATA));
    snap_ok = (32'(SnapSel) < 32'(SNAP_SLOTS)) && (32'(SnapIdx) < 32'(DEPTH));
  end

  // Shared bus: only driven during the wait/data period of a read
  assign Data = rd_drive ? rd_word : {DATA_W{1'bz}};

  // Next-state logic for the target transaction FSM
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (!F) begin
          if (RE ^ WE) begin
            next_state = (WAIT_STATES > 0) ? S_WAIT : S_DATA;
          end else begin
            next_state = S_IGNORE;
          end
        end
      end
      S_WAIT: begin
        // counter was loaded with WAIT_STATES, leave on the edge it hits 0
        if (wait_cnt <= 4'd1) next_state = S_DATA;
      end
      S_DATA: begin
        if (xfer && F) next_state = S_TURN;
      end
      S_IGNORE: begin
        if (F) next_state = S_IDLE;
      end
      S_TURN: begin
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // State register with TRDY/DEVSEL registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      T     <= 1'b1;
      D     <= 1'b1;
    end else begin
      state <= next_state;
      T     <= (next_state != S_DATA);
      D     <= !((next_state == S_WAIT) || (next_state == S_DATA));
    end
  end

  // Address-phase capture, wait counter and burst pointer advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Ptr      <= '0;
      is_write <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if ((state == S_IDLE) && !F) begin
        Ptr      <= Address;
        is_write <= WE;
        wait_cnt <= 4'(WAIT_STATES);
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - 4'd1;
      end else if (xfer) begin
        Ptr <= ptr_inc;
      end
    end
  end

  // Storage words: cleared on reset, byte-lane writes on write transfers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem[w] <= '0;
      end
    end else if (xfer && is_write && ptr_ok) begin
      for (int k = 0; k < BYTES; k++) begin
        if (BE[k]) mem[Ptr][8*k +: 8] <= Data[8*k +: 8];
      end
    end
  end

  // Snapshot ring bookkeeping: slot pointer and saturating valid count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_slot    <= '0;
      snap_count <= '0;
    end else if ((state == S_TURN) && is_write) begin
      wr_slot <= (32'(wr_slot) >= 32'(SNAP_SLOTS - 1)) ? '0 : wr_slot + SEL_W'(1);
      if (snap_count < 4'(SNAP_SLOTS)) snap_count <= snap_count + 4'd1;
    end
  end

  // Snapshot contents survive reset; capture the whole store in TURN
  always_ff @(posedge clk) begin
    if (!rst && (state == S_TURN) && is_write) begin
      snap[wr_slot] <= mem;
    end
  end

  // Snapshot read port
  always_comb begin
    SnapData = snap_ok ? snap[SnapSel][SnapIdx] : '0;
  end

  assign SnapCount = snap_count;

endmodule

// File: tb/tb_pci_target_mem.sv
// Testbench for pci_target_mem: directed plus randomized transactions on a
// zero-wait-state instance, and a short directed run on a two-wait-state
// instance. Expected values come from a word-array model of the store.
module tb_pci_target_mem;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst2 = 1'b1;
  logic        f0 = 1'b1;
  logic        f2 = 1'b1;
  logic        irdy = 1'b1;
  logic [1:0]  addr = '0;
  logic        re = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic        snap_sel = 1'b0;
  logic [1:0]  snap_idx = '0;
  logic        tb_drv = 1'b0;
  logic [31:0] tb_data = '0;

  wire  [31:0] data0;
  wire  [31:0] data2;
  logic        t0, d0, t2, d2;
  logic [1:0]  ptr0, ptr2;
  logic [31:0] sdata0, sdata2;
  logic [3:0]  scount0, scount2;

  assign data0 = tb_drv ? tb_data : 32'hzzzz_zzzz;
  assign data2 = tb_drv ? tb_data : 32'hzzzz_zzzz;

  pci_target_mem #(.DATA_W(32), .DEPTH(4), .WAIT_STATES(0), .SNAP_SLOTS(2)) dut0 (
    .clk(clk), .rst(rst), .Data(data0), .F(f0), .I(irdy), .Address(addr),
    .RE(re), .WE(we), .BE(be), .T(t0), .D(d0), .Ptr(ptr0),
    .SnapSel(snap_sel), .SnapIdx(snap_idx), .SnapData(sdata0), .SnapCount(scount0)
  );

  pci_target_mem #(.DATA_W(32), .DEPTH(4), .WAIT_STATES(2), .SNAP_SLOTS(2)) dut2 (
    .clk(clk), .rst(rst2), .Data(data2), .F(f2), .I(irdy), .Address(addr),
    .RE(re), .WE(we), .BE(be), .T(t2), .D(d2), .Ptr(ptr2),
    .SnapSel(snap_sel), .SnapIdx(snap_idx), .SnapData(sdata2), .SnapCount(scount2)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: run did not finish in time");
    $fatal(1, "timeout");
  end

  // scoreboard counters and reference model of dut0
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_mem [4];
  logic [31:0] m_snap [2][4];
  bit          m_snap_valid [2];
  int          m_ptr, m_slot, m_cnt;
  logic [31:0] b_data [16];
  logic [3:0]  b_be [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 4; w++) m_mem[w] = '0;
    m_ptr = 0; m_slot = 0; m_cnt = 0;
  endtask

  // drive a private pattern and expect to read it back: nobody else drives
  task automatic chk_released(input string tag);
    logic [31:0] pat;
    pat = $urandom;
    tb_drv = 1'b1; tb_data = pat;
    #1;
    chk(tag, data0, pat);
    tb_drv = 1'b0;
  endtask

  task automatic chk_snaps();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4; i++) begin
        if (m_snap_valid[s]) begin
          snap_sel = s[0]; snap_idx = i[1:0];
          #1;
          chk($sformatf("snap[%0d][%0d]", s, i), sdata0, m_snap[s][i]);
        end
      end
    end
  endtask

  // one complete transaction on dut0 using b_data/b_be; optional single
  // IRDY-high stall cycle after beat stall_after
  task automatic xact0(input bit wr, input int start, input int n, input int stall_after);
    @(negedge clk);
    f0 = 1'b0; addr = start[1:0]; re = !wr; we = wr; irdy = 1'b1;
    @(posedge clk);
    m_ptr = start;
    @(negedge clk);
    chk("devsel_on", d0, 1'b0);
    chk("trdy_on", t0, 1'b0);
    re = 1'b0; we = 1'b0;
    for (int b = 0; b < n; b++) begin
      if (!wr) chk("rd_data", data0, m_mem[m_ptr]);
      tb_drv = wr; tb_data = b_data[b]; be = b_be[b]; irdy = 1'b0;
      f0 = (b == n - 1);
      @(posedge clk);
      if (wr) begin
        for (int k = 0; k < 4; k++)
          if (b_be[b][k]) m_mem[m_ptr][8*k +: 8] = b_data[b][8*k +: 8];
      end
      m_ptr = (m_ptr + 1) % 4;
      @(negedge clk);
      chk("ptr_adv", ptr0, m_ptr[1:0]);
      if (b == stall_after && b != n - 1) begin
        irdy = 1'b1; f0 = 1'b0; tb_drv = 1'b0;
        chk("stall_trdy", t0, 1'b0);
        if (!wr) chk("stall_data", data0, m_mem[m_ptr]);
        @(posedge clk);
        @(negedge clk);
        chk("stall_ptr", ptr0, m_ptr[1:0]);
        chk("stall_trdy2", t0, 1'b0);
      end
    end
    tb_drv = 1'b0; irdy = 1'b1; f0 = 1'b1;
    chk("turn_trdy", t0, 1'b1);
    chk("turn_devsel", d0, 1'b1);
    chk_released("turn_bus");
    @(posedge clk);
    if (wr) begin
      m_snap[m_slot] = m_mem;
      m_snap_valid[m_slot] = 1'b1;
      m_slot = (m_slot + 1) % 2;
      m_cnt = (m_cnt + 1 > 2) ? 2 : m_cnt + 1;
    end
    @(negedge clk);
    chk("snap_count", scount0, m_cnt);
    chk("ptr_end", ptr0, m_ptr[1:0]);
  endtask

  // directed and random stimulus, then final report
  initial begin
    int n, st;
    bit wr;
    logic [31:0] w2;

    model_reset();
    m_snap_valid[0] = 1'b0; m_snap_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_trdy", t0, 1'b1);
    chk("rst_devsel", d0, 1'b1);
    chk("rst_ptr", ptr0, 2'd0);
    chk("rst_count", scount0, 4'd0);
    chk_released("rst_bus");

    // burst write with partial byte enables
    b_data[0] = 32'h0000_0002; b_be[0] = 4'b1111;
    b_data[1] = 32'h0000_ff00; b_be[1] = 4'b0010;
    b_data[2] = 32'h0000_0004; b_be[2] = 4'b1111;
    xact0(1'b1, 0, 3, -1);
    chk("bw_ptr", ptr0, 2'd3);
    chk("bw_count", scount0, 4'd1);
    snap_sel = 1'b0; snap_idx = 2'd1; #1;
    chk("bw_mem1", sdata0, 32'h0000_ff00);
    chk_snaps();

    // wrapping write from the last word
    b_data[0] = 32'hA; b_be[0] = 4'hf;
    b_data[1] = 32'hB; b_be[1] = 4'hf;
    xact0(1'b1, 3, 2, -1);
    chk("wrap_ptr", ptr0, 2'd1);
    snap_sel = 1'b1; snap_idx = 2'd0; #1;
    chk("wrap_mem0", sdata0, 32'hB);
    snap_idx = 2'd3; #1;
    chk("wrap_mem3", sdata0, 32'hA);

    // read with one IRDY stall after the first beat
    xact0(1'b0, 0, 3, 0);

    // RE==WE is ignored
    @(negedge clk);
    f0 = 1'b0; re = 1'b1; we = 1'b1; addr = 2'd2;
    @(posedge clk);
    @(negedge clk);
    re = 1'b0; we = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chk("ign_trdy", t0, 1'b1);
      chk("ign_devsel", d0, 1'b1);
      @(posedge clk); @(negedge clk);
    end
    f0 = 1'b1;
    @(posedge clk);
    xact0(1'b0, 0, 4, -1);

    // randomized transactions
    for (int r = 0; r < 24; r++) begin
      wr = $urandom_range(0, 1);
      n = $urandom_range(1, 6);
      st = int'($urandom_range(0, n)) - 1;
      for (int b = 0; b < n; b++) begin
        b_data[b] = $urandom;
        b_be[b] = 4'($urandom_range(0, 15));
      end
      xact0(wr, $urandom_range(0, 3), n, st);
    end
    chk_snaps();

    // reset in the middle of a write burst
    @(negedge clk);
    f0 = 1'b0; addr = 2'd0; we = 1'b1; re = 1'b0; irdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    we = 1'b0;
    for (int b = 0; b < 2; b++) begin
      tb_drv = 1'b1; tb_data = $urandom | 32'h1; be = 4'hf; irdy = 1'b0;
      @(posedge clk); @(negedge clk);
    end
    rst = 1'b1; tb_drv = 1'b0; irdy = 1'b1; f0 = 1'b1;
    #1;
    chk("mid_rst_trdy", t0, 1'b1);
    chk("mid_rst_devsel", d0, 1'b1);
    chk("mid_rst_ptr", ptr0, 2'd0);
    chk("mid_rst_count", scount0, 4'd0);
    chk_released("mid_rst_bus");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    xact0(1'b0, 0, 4, -1);
    chk_snaps();

    // snapshot ring: three writes of word 0
    for (int v = 1; v <= 3; v++) begin
      b_data[0] = v; b_be[0] = 4'hf;
      xact0(1'b1, 0, 1, -1);
    end
    chk("ring_count", scount0, 4'd2);
    snap_sel = 1'b0; snap_idx = 2'd0; #1;
    chk("ring_snap0", sdata0, 32'd3);
    snap_sel = 1'b1; #1;
    chk("ring_snap1", sdata0, 32'd2);

    // two wait states on dut2
    @(negedge clk);
    rst2 = 1'b0;
    w2 = $urandom;
    @(negedge clk);
    f2 = 1'b0; addr = 2'd0; we = 1'b1; re = 1'b0; irdy = 1'b1;
    @(posedge clk);                      // edge N
    @(negedge clk);
    we = 1'b0;
    chk("ws_devsel_n1", d2, 1'b0);
    chk("ws_trdy_n1", t2, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("ws_devsel_n2", d2, 1'b0);
    chk("ws_trdy_n2", t2, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("ws_trdy_n3", t2, 1'b0);
    tb_drv = 1'b1; tb_data = w2; be = 4'hf; irdy = 1'b0; f2 = 1'b1;
    @(posedge clk);                      // edge N+3: first transfer
    @(negedge clk);
    tb_drv = 1'b0; irdy = 1'b1;
    chk("ws_turn_trdy", t2, 1'b1);
    chk("ws_ptr", ptr2, 2'd1);
    @(posedge clk); @(negedge clk);
    chk("ws_count", scount2, 4'd1);
    snap_sel = 1'b0; snap_idx = 2'd0; #1;
    chk("ws_word0", sdata2, w2);
    f2 = 1'b0; re = 1'b1; we = 1'b1;
    @(posedge clk); @(negedge clk);
    re = 1'b0; we = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("ws_ign_devsel", d2, 1'b1);
      chk("ws_ign_trdy", t2, 1'b1);
      @(posedge clk); @(negedge clk);
    end
    f2 = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("ws_ign_count", scount2, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pci_target_mem.md
# pci_target_mem

Parametrised PCI-style target storage: a DEPTH-word register file with per-byte enables, burst transfers with wrapping address increment, a proper TRDY/DEVSEL handshake with programmable wait states, and a ring of snapshot buffers captured at the end of every write transaction. It sits behind the PCI slave bus interface in place of the fixed 3-word store, runs entirely on the rising clock edge, and drives the shared Data bus only during its own read data phases.

## Interface
- DATA_W, 32, data width in bits; multiple of 8.
- DEPTH, 4, number of storage words; 2..256.
- ADDR_W, $clog2(DEPTH), word-address width.
- WAIT_STATES, 0, TRDY wait cycles inserted after the address phase; 0..15.
- SNAP_SLOTS, 2, number of snapshot buffers; 1..8.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- Data  inout  DATA_W  shared data bus; driven only during read data phases, otherwise high-Z.
- F  in  1  FRAME, active low; low = transaction in progress.
- I  in  1  IRDY, active low; initiator ready.
- Address  in  ADDR_W  start word address, sampled in the address phase.
- RE  in  1  read command, sampled in the address phase.
- WE  in  1  write command, sampled in the address phase.
- BE  in  DATA_W/8  byte enables, active high, sampled per data phase.
- T  out  1  TRDY, active low, registered.
- D  out  1  DEVSEL, active low, registered.
- Ptr  out  ADDR_W  current word pointer.
- SnapSel  in  $clog2(SNAP_SLOTS) (min 1)  snapshot slot select.
- SnapIdx  in  ADDR_W  word select within the slot.
- SnapData  out  DATA_W  snap[SnapSel][SnapIdx], combinational.
- SnapCount  out  4  number of valid slots, saturates at SNAP_SLOTS.

## Operation
- States: IDLE, WAIT, DATA, IGNORE, TURN.
- IDLE: T=1, D=1, Data high-Z. A rising edge with F=0 is the address phase: Ptr<=Address, latch RE/WE. RE xor WE → WAIT if WAIT_STATES>0 (counter loaded), else DATA. RE==WE → IGNORE.
- IGNORE: T=1, D=1, no storage access; returns to IDLE on the first edge with F=1.
- WAIT: D=0, T=1; counter decrements each cycle; enters DATA when the counter reaches 0.
- DATA: D=0, T=0. A transfer occurs on each rising edge with T=0 and I=0.
  - Write: for each k with BE[k]=1, mem[Ptr][8k+7:8k]<=Data[8k+7:8k]; lanes with BE[k]=0 are unchanged.
  - Read: Data=mem[Ptr] (combinational from registered Ptr) for the whole DATA/WAIT period of a read.
  - After a transfer: Ptr<=Ptr+1, wrapping DEPTH-1→0 (also for non-power-of-2 DEPTH).
  - I=1: no transfer; Ptr and mem hold; T stays 0.
  - A transfer with F=1 is the last data phase → TURN. F=1 with I=1 → stay in DATA.
- TURN: one cycle, T=1, D=1, Data released. For a write transaction: snap[wr_slot]<=mem (all words, including the final write); wr_slot<=wr_slot+1 mod SNAP_SLOTS; SnapCount<=min(SnapCount+1, SNAP_SLOTS). Then → IDLE.
- Read transactions never capture a snapshot.
- Reset (any time, including mid-burst): state=IDLE, T=1, D=1, Data high-Z, Ptr=0, all mem words=0, wr_slot=0, SnapCount=0. Snapshot contents are not cleared. Reset dominates all simultaneous events; a partially completed burst keeps no writes after reset.

## Timing
- The address phase is edge N (F=0 sampled). With WAIT_STATES=W, D=0 from N+1 and T=0 from N+1+W. The first transfer is possible at edge N+1+W.
- One word per cycle while I=0; no dead cycles between beats.
- Write data and BE are sampled on the transfer edge; mem is visible on the read path and on the snapshot in the next cycle.
- Read data is valid whenever T=0; it changes only after a transfer edge.
- TURN lasts exactly one cycle. A new address phase is accepted on the edge after TURN (IDLE). Back-to-back transactions therefore have a minimum 1-cycle gap.
- SnapCount and the new slot contents are visible after the TURN edge.

## Test plan
- Reset: assert rst mid-write-burst at DEPTH=4 → T=1, D=1, Data=Z, Ptr=0, SnapCount=0, and mem[0..3] read back 0 in the following read burst.
- Burst write from Address=0: beats 0x00000002 with BE=1111, 0x0000ff00 with BE=0010, 0x00000004 with BE=1111 (F=1 on beat 3) → mem[0]=2, mem[1][15:8]=0xff with other bytes 0, mem[2]=4, Ptr=3, SnapCount=1.
- Wrap: DEPTH=4, write 0xA then 0xB starting at Address=3 → mem[3]=0xA, mem[0]=0xB, Ptr=1.
- Read with IRDY stall: read from 0 with I=1 for one cycle after the first beat → Data holds mem[1] for 2 cycles with T=0, Ptr holds, then mem[2] is delivered.
- WAIT_STATES=2: address phase at edge N → D=0 at N+1, T=0 at N+3, first write lands at edge N+3; RE=WE=1 → D and T stay 1, mem unchanged.
- Snapshot ring, SNAP_SLOTS=2: three write transactions writing mem[0]=1, 2, 3 → SnapCount=2, snap[0][0]=3, snap[1][0]=2.
